msa_scheduler: RTL
==================

# msa_scheduler

Round-robin scheduler that shares one SHA-256 message-schedule extender (`msa_extender`) among `NUM_REQ` hash lanes. It accepts 512-bit chunks from the lanes and grants one lane at a time. It drives the extender's chunk handshake, then returns the extender's 64-word schedule to the granted lane tagged with the lane index. It sits between the per-lane chunk builders and the shared extender, upstream of the compression stages.

## Interface
- `NUM_REQ`, 4: number of requesting lanes, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: width of the lane index.
- `WDOG_CYCLES`, 64: watchdog limit in cycles. Used only when `MSA_SCHED_WATCHDOG_EN` is defined.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `req_vld` in `NUM_REQ`: per-lane chunk valid.
- `req_rdy` out `NUM_REQ`: per-lane chunk accept, one-hot or zero.
- `req_chunk` in `NUM_REQ`×`chunk_t`: per-lane 16×32-bit chunk.
- `ext_chunk_vld` out 1: to extender `chunk_vld`.
- `ext_chunk_rdy` in 1: from extender `chunk_rdy`.
- `ext_chunk_data` out `chunk_t`: to extender `chunk_data`.
- `ext_w_vld` in 1: from extender `w_vld`.
- `ext_w_rdy` out 1: to extender `w_rdy`.
- `ext_w` in `sched_t`: from extender `w`.
- `rsp_vld` out 1: schedule valid toward the lanes.
- `rsp_rdy` in 1: downstream accept.
- `rsp_id` out `ID_W`: lane that owns `rsp_w`.
- `rsp_w` out `sched_t`: 64×32-bit schedule.
- `err_timeout` out 1: one-cycle pulse when the watchdog aborts a job.

## Operation
- States (`MsaSchedState`):
  - IDLE: arbitrate.
  - ISSUE: present the chunk to the extender.
  - WAIT: wait for the schedule and forward it.
- Reset (`rst`=0) forces:
  - state IDLE, pointer `ptr`=0, `gnt_id`=0, `chunk_q`=0, watchdog count 0;
  - all outputs 0.
- Reset mid-job abandons the job silently. The extender has its own sync reset, owned by the top level.
- IDLE arbitration:
  - Combinationally select the first `req_vld[i]`, searching from `ptr` upward with wrap at `NUM_REQ`.
  - `req_rdy[sel]`=1 only in IDLE and only when any `req_vld` is high.
  - On that handshake: `chunk_q`<=`req_chunk[sel]`, `gnt_id`<=`sel`, `ptr`<=(`sel`+1) mod `NUM_REQ`, then go to ISSUE.
  - No request: stay in IDLE, `ptr` unchanged.
- ISSUE:
  - `ext_chunk_vld`=1 and `ext_chunk_data`=`chunk_q`.
  - On `ext_chunk_vld & ext_chunk_rdy`, go to WAIT. `ext_chunk_vld` is 0 from the next cycle on.
  - `ext_chunk_data` holds `chunk_q` in every state. The extender samples its data on valid alone, so the data must never change while valid is high.
- WAIT:
  - `rsp_vld`=`ext_w_vld`, `ext_w_rdy`=`rsp_rdy`, `rsp_w`=`ext_w`, `rsp_id`=`gnt_id`. Pure pass-through, no storage.
  - On `rsp_vld & rsp_rdy`, go to IDLE.
- Outside WAIT: `rsp_vld`=0 and `ext_w_rdy`=0, even if `ext_w_vld` is high.
- Lanes must hold `req_vld` and `req_chunk` stable until `req_rdy`. Deasserting `req_vld` earlier is legal and simply withdraws the request.
- Only one job is in flight. New requests wait in IDLE.

## Timing
- Lane handshake to `ext_chunk_vld`: 1 cycle.
- `ext_chunk_vld` hold time: until the extender's registered `chunk_rdy`, typically 2–3 cycles.
- Extender processing adds about 22 cycles. Total from lane handshake to `rsp_vld` is about 26 cycles; the bench checks order and ownership, not an exact count.
- Back-to-back jobs: after the `rsp` handshake, the earliest next `req_rdy` is the following cycle (IDLE).
- Fairness: with all lanes requesting continuously, grants rotate 0,1,…,`NUM_REQ`-1,0. No lane waits more than `NUM_REQ`-1 jobs.
- A request raised on the same cycle as the `rsp` handshake is seen in IDLE on the next cycle.

## Configuration
- `MSA_SCHED_WATCHDOG_EN` defined:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - It freezes while `ext_w_vld & ~rsp_rdy`, so downstream backpressure is not a fault.
  - When it reaches `WDOG_CYCLES`, `err_timeout` pulses for 1 cycle and the state goes to IDLE. The job is dropped and `ptr` stays already advanced.
- Undefined: no counter exists, `err_timeout` is tied to 0, and the port remains present.

## Structure
- `sha256_pkg` adds:
  - `typedef logic [15:0][31:0] chunk_t;`
  - `typedef logic [63:0][31:0] sched_t;`
  - the `MsaSchedState` enum.
- Sub-module `rr_arbiter`: parameterised by `NUM_REQ`. Inputs are the request vector and `ptr`; outputs are `any`, `sel` index and one-hot grant. Purely combinational.
- `msa_scheduler` owns the FSM, `chunk_q`, `ptr`, `gnt_id` and the watchdog.

## Test plan
- Single lane 2 requests chunk `"abc"` padded; extender model returns a schedule → `rsp_id`=2, `rsp_w[16]`=0x61626380 ^ expected `σ` sums matching the golden model, and `req_rdy` pulses exactly once.
- All 4 lanes assert simultaneously from reset → grant order 0,1,2,3,0, with `rsp_id` matching at each response.
- `rsp_rdy` held low for 10 cycles while `ext_w_vld`=1 → `rsp_w` stable, `ext_w_rdy`=0, no new `req_rdy`; the job completes when `rsp_rdy` rises.
- Lane 1 drops `req_vld` before grant while lane 3 is valid → lane 3 granted and `ptr` becomes 0.
- Assert `rst`=0 in WAIT → outputs 0 immediately; after release, a new lane 0 request is granted first.
- Watchdog build with the extender never asserting `ext_w_vld` and `WDOG_CYCLES`=64 → `err_timeout` pulses 64 cycles after ISSUE entry and the state returns to IDLE. In a non-watchdog build, `err_timeout` stays 0 and the scheduler hangs in WAIT.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 datapath types and message-schedule scheduler states
package sha256_pkg;

  typedef logic [15:0][31:0] chunk_t;
  typedef logic [63:0][31:0] sched_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } MsaSchedState;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or above ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    sel,
  output logic [NUM_REQ-1:0] gnt
);

  int              idx_i;
  logic [ID_W-1:0] idx;

  always_comb begin
    any   = 1'b0;
    sel   = '0;
    gnt   = '0;
    idx_i = 0;
    idx   = '0;
    // Wrap by subtraction so non-power-of-two lane counts stay in range.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_i = int'(ptr) + i;
      if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
      idx = idx_i[ID_W-1:0];
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
    if (any) gnt[sel] = 1'b1;
  end

endmodule

// File: rtl/msa_scheduler.sv
// rtl/msa_scheduler.sv - round-robin share of one SHA-256 message-schedule extender
// Optional job watchdog is built when MSA_SCHED_WATCHDOG_EN is defined.
module msa_scheduler
  import sha256_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int WDOG_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_vld,
  output logic [NUM_REQ-1:0]  req_rdy,
  input  chunk_t [NUM_REQ-1:0] req_chunk,
  output logic                ext_chunk_vld,
  input  logic                ext_chunk_rdy,
  output chunk_t              ext_chunk_data,
  input  logic                ext_w_vld,
  output logic                ext_w_rdy,
  input  sched_t              ext_w,
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [ID_W-1:0]     rsp_id,
  output sched_t              rsp_w,
  output logic                err_timeout
);

  MsaSchedState       state_q, state_d;
  logic [ID_W-1:0]    ptr_q, gnt_id_q, arb_sel, ptr_nxt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_any, lane_hs, rsp_hs, wdog_hit;
  chunk_t             chunk_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (req_vld),
    .ptr (ptr_q),
    .any (arb_any),
    .sel (arb_sel),
    .gnt (arb_gnt)
  );

  // rst gates the grant so no lane sees a handshake while reset is held.
  assign lane_hs = (state_q == ST_IDLE) && arb_any && rst;
  assign rsp_hs  = (state_q == ST_WAIT) && ext_w_vld && rsp_rdy;
  assign ptr_nxt = (arb_sel == ID_W'(NUM_REQ - 1)) ? '0 : arb_sel + ID_W'(1);

  assign ext_chunk_data = chunk_q;
  assign rsp_id         = gnt_id_q;

  always_comb begin
    state_d       = state_q;
    req_rdy       = '0;
    ext_chunk_vld = 1'b0;
    ext_w_rdy     = 1'b0;
    rsp_vld       = 1'b0;
    rsp_w         = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (lane_hs) begin
          req_rdy = arb_gnt;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ext_chunk_vld = 1'b1;
        if (ext_chunk_rdy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        rsp_vld   = ext_w_vld;
        ext_w_rdy = rsp_rdy;
        rsp_w     = ext_w;
        if (rsp_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (wdog_hit) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      chunk_q  <= '0;
    end else begin
      state_q <= state_d;
      if (lane_hs) begin
        chunk_q  <= req_chunk[arb_sel];
        gnt_id_q <= arb_sel;
        ptr_q    <= ptr_nxt;
      end
    end
  end

`ifdef MSA_SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              wdog_run, err_q;

  // Downstream backpressure on a ready schedule is not counted as a stall.
  assign wdog_run = (state_q != ST_IDLE) && !(ext_w_vld && !rsp_rdy);
  assign wdog_hit = wdog_run && !rsp_hs && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= wdog_hit;
      if (lane_hs) wdog_q <= '0;
      else if (wdog_run) wdog_q <= wdog_q + WDOG_W'(1);
    end
  end
`else
  assign wdog_hit    = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
